// File: rtl/stim_sequencer.sv
// Four-channel biphasic pulse-train scheduler; timing advances once per TX_END frame tick.
// Latency: START/TX_END/STOP effects are registered and visible the next cycle; strobes are never stalled.
module stim_sequencer #(
    parameter int                 AMP_W    = 8,
    parameter int                 CNT_W    = 16,
    parameter logic [AMP_W-1:0]   IDLE_AMP = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_WR,
    input  logic [1:0]       CFG_CH,
    input  logic [2:0]       CFG_SEL,
    input  logic [CNT_W-1:0] CFG_DATA,
    output logic             CFG_ERR,
    input  logic             START,
    input  logic [3:0]       CH_MASK,
    input  logic             STOP,
    input  logic             TX_END,
    output logic [AMP_W-1:0] AMP0,
    output logic [AMP_W-1:0] AMP1,
    output logic [AMP_W-1:0] AMP2,
    output logic [AMP_W-1:0] AMP3,
    output logic [3:0]       BUSY,
    output logic [3:0]       DONE,
    output logic             ACTIVE
);

    typedef enum logic [2:0] {S_IDLE, S_PH1, S_IPG, S_PH2, S_REST} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] pw1;
        logic [CNT_W-1:0] ipg;
        logic [CNT_W-1:0] pw2;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] npulse;
        logic [AMP_W-1:0] amp_p1;
        logic [AMP_W-1:0] amp_p2;
    } cfg_t;

    typedef struct packed {
        state_t           st;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] pcnt;
        logic             done;
    } step_t;

    cfg_t             cfg_q  [4];
    state_t           st_q   [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] pcnt_q [4];
    logic [AMP_W-1:0] amp_q  [4];
    logic [3:0]       done_q;
    logic             cfg_err_q;

    logic [CNT_W-1:0] rest_w [4];
    logic             zero_w [4];
    step_t            nxt    [4];
    logic             wr_ok;

    // First non-empty phase at or after 'from' (PH1, IPG or PH2); S_IDLE if all remaining are empty.
    function automatic step_t first_phase(input state_t from, input cfg_t c, input logic [CNT_W-1:0] pc);
        step_t s;
        s.st = S_IDLE; s.cnt = '0; s.pcnt = pc; s.done = 1'b0;
        if (from == S_PH1 && c.pw1 != '0) begin
            s.st = S_PH1; s.cnt = c.pw1;
        end else if (from != S_PH2 && c.ipg != '0) begin
            s.st = S_IPG; s.cnt = c.ipg;
        end else if (c.pw2 != '0) begin
            s.st = S_PH2; s.cnt = c.pw2;
        end
        return s;
    endfunction

    // Pulse bookkeeping at the end of a pulse: finish the train or move on to REST / next PH1.
    function automatic step_t account(input cfg_t c, input logic [CNT_W-1:0] pc,
                                      input logic [CNT_W-1:0] rest, input logic zero);
        step_t s;
        s.st = S_REST; s.cnt = zero ? CNT_W'(1) : rest; s.pcnt = pc; s.done = 1'b0;
        if (c.npulse != '0 && pc == CNT_W'(1)) begin
            s.st = S_IDLE; s.cnt = '0; s.done = 1'b1;
        end else begin
            if (c.npulse != '0)
                s.pcnt = pc - CNT_W'(1);
            if (!zero && rest == '0)
                s = first_phase(S_PH1, c, s.pcnt);
        end
        return s;
    endfunction

    // With every duration zero the pulse is accounted at the end of its forced 1-tick REST,
    // so no pulse ever completes in zero time.
    function automatic step_t pulse_end(input cfg_t c, input logic [CNT_W-1:0] pc,
                                        input logic [CNT_W-1:0] rest, input logic zero);
        step_t s;
        if (zero) begin
            s.st = S_REST; s.cnt = CNT_W'(1); s.pcnt = pc; s.done = 1'b0;
        end else begin
            s = account(c, pc, rest, zero);
        end
        return s;
    endfunction

    function automatic step_t seek(input state_t from, input cfg_t c, input logic [CNT_W-1:0] pc,
                                   input logic [CNT_W-1:0] rest, input logic zero);
        step_t s;
        s = first_phase(from, c, pc);
        if (s.st == S_IDLE)
            s = pulse_end(c, pc, rest, zero);
        return s;
    endfunction

    always_comb begin
        logic [CNT_W+1:0] sum;
        logic [CNT_W+1:0] diff;
        sum  = '0;
        diff = '0;
        for (int n = 0; n < 4; n++) begin
            sum  = {2'b00, cfg_q[n].pw1} + {2'b00, cfg_q[n].ipg} + {2'b00, cfg_q[n].pw2};
            diff = {2'b00, cfg_q[n].period} - sum;
            rest_w[n] = (diff[CNT_W+1] || diff == '0) ? '0 : diff[CNT_W-1:0];
            zero_w[n] = (sum == '0) && (rest_w[n] == '0);
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            nxt[n].st   = st_q[n];
            nxt[n].cnt  = cnt_q[n];
            nxt[n].pcnt = pcnt_q[n];
            nxt[n].done = 1'b0;
            if (STOP) begin
                nxt[n].st  = S_IDLE;
                nxt[n].cnt = '0;
            end else if (st_q[n] == S_IDLE) begin
                if (START && CH_MASK[n])
                    nxt[n] = seek(S_PH1, cfg_q[n], cfg_q[n].npulse, rest_w[n], zero_w[n]);
            end else if (TX_END) begin
                if (cnt_q[n] > CNT_W'(1)) begin
                    nxt[n].cnt = cnt_q[n] - CNT_W'(1);
                end else begin
                    case (st_q[n])
                        S_PH1:   nxt[n] = seek(S_IPG, cfg_q[n], pcnt_q[n], rest_w[n], zero_w[n]);
                        S_IPG:   nxt[n] = seek(S_PH2, cfg_q[n], pcnt_q[n], rest_w[n], zero_w[n]);
                        S_PH2:   nxt[n] = pulse_end(cfg_q[n], pcnt_q[n], rest_w[n], zero_w[n]);
                        default: nxt[n] = zero_w[n] ? account(cfg_q[n], pcnt_q[n], rest_w[n], zero_w[n])
                                                    : seek(S_PH1, cfg_q[n], pcnt_q[n], rest_w[n], zero_w[n]);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < 4; n++) begin
                st_q[n]   <= S_IDLE;
                cnt_q[n]  <= '0;
                pcnt_q[n] <= '0;
                amp_q[n]  <= IDLE_AMP;
            end
            done_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                st_q[n]   <= nxt[n].st;
                cnt_q[n]  <= nxt[n].cnt;
                pcnt_q[n] <= nxt[n].pcnt;
                done_q[n] <= nxt[n].done;
                amp_q[n]  <= (nxt[n].st == S_PH1) ? cfg_q[n].amp_p1 :
                             (nxt[n].st == S_PH2) ? cfg_q[n].amp_p2 : IDLE_AMP;
            end
        end
    end

    // A channel being armed this cycle counts as busy for the write check.
    assign wr_ok = CFG_WR && (CFG_SEL != 3'd7) && (st_q[CFG_CH] == S_IDLE) && !(START && CH_MASK[CFG_CH]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < 4; n++)
                cfg_q[n] <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= CFG_WR && !wr_ok;
            if (wr_ok) begin
                case (CFG_SEL)
                    3'd0:    cfg_q[CFG_CH].pw1    <= CFG_DATA;
                    3'd1:    cfg_q[CFG_CH].ipg    <= CFG_DATA;
                    3'd2:    cfg_q[CFG_CH].pw2    <= CFG_DATA;
                    3'd3:    cfg_q[CFG_CH].period <= CFG_DATA;
                    3'd4:    cfg_q[CFG_CH].npulse <= CFG_DATA;
                    3'd5:    cfg_q[CFG_CH].amp_p1 <= CFG_DATA[AMP_W-1:0];
                    default: cfg_q[CFG_CH].amp_p2 <= CFG_DATA[AMP_W-1:0];
                endcase
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++)
            BUSY[n] = (st_q[n] != S_IDLE);
    end

    assign ACTIVE  = |BUSY;
    assign DONE    = done_q;
    assign CFG_ERR = cfg_err_q;
    assign AMP0    = amp_q[0];
    assign AMP1    = amp_q[1];
    assign AMP2    = amp_q[2];
    assign AMP3    = amp_q[3];

endmodule

// File: tb/tb_stim_sequencer.sv
// Bench for stim_sequencer: a per-tick train model predicts every cycle's outputs into a
// scoreboard queue that a negedge monitor drains; directed scenarios plus random traffic.
module tb_stim_sequencer;
    localparam int AMP_W = 8;
    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RST, CFG_WR, START, STOP, TX_END;
    logic [1:0]       CFG_CH;
    logic [2:0]       CFG_SEL;
    logic [CNT_W-1:0] CFG_DATA;
    logic [3:0]       CH_MASK;
    logic             CFG_ERR, ACTIVE;
    logic [AMP_W-1:0] AMP0, AMP1, AMP2, AMP3;
    logic [3:0]       BUSY, DONE;

    always #5 CLK = ~CLK;

    stim_sequencer #(.AMP_W(AMP_W), .CNT_W(CNT_W), .IDLE_AMP(8'd0)) dut (
        .CLK(CLK), .RST(RST), .CFG_WR(CFG_WR), .CFG_CH(CFG_CH), .CFG_SEL(CFG_SEL),
        .CFG_DATA(CFG_DATA), .CFG_ERR(CFG_ERR), .START(START), .CH_MASK(CH_MASK),
        .STOP(STOP), .TX_END(TX_END), .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2), .AMP3(AMP3),
        .BUSY(BUSY), .DONE(DONE), .ACTIVE(ACTIVE)
    );

    typedef struct packed {
        logic [7:0] a0, a1, a2, a3;
        logic [3:0] busy, done;
        logic       active, err;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: registers plus, per running channel, the tick index into its train.
    int unsigned r_pw1[4], r_ipg[4], r_pw2[4], r_per[4], r_np[4];
    logic [7:0]  r_a1[4], r_a2[4];
    bit          m_busy[4];
    int unsigned m_k[4], m_len[4], m_per[4];
    bit          m_fin[4];

    function automatic logic [7:0] amp_at(int ch);
        int unsigned j;
        j = m_k[ch] % m_per[ch];
        if (j < r_pw1[ch]) return r_a1[ch];
        if (j < r_pw1[ch] + r_ipg[ch]) return 8'd0;
        if (j < r_pw1[ch] + r_ipg[ch] + r_pw2[ch]) return r_a2[ch];
        return 8'd0;
    endfunction

    task automatic start_ch(int ch);
        int unsigned sum, rest;
        bit zero;
        sum  = r_pw1[ch] + r_ipg[ch] + r_pw2[ch];
        rest = (r_per[ch] > sum) ? r_per[ch] - sum : 0;
        zero = (sum == 0) && (rest == 0);
        m_busy[ch] = 1'b1;
        m_k[ch]    = 0;
        m_fin[ch]  = (r_np[ch] != 0);
        m_per[ch]  = zero ? 1 : sum + rest;
        m_len[ch]  = zero ? r_np[ch] : r_np[ch] * sum + (r_np[ch] - 1) * rest;
    endtask

    task automatic model_edge();
        obs_t e;
        bit   ok;
        e = '0;
        if (RST) begin
            for (int c = 0; c < 4; c++) begin
                r_pw1[c] = 0; r_ipg[c] = 0; r_pw2[c] = 0; r_per[c] = 0; r_np[c] = 0;
                r_a1[c] = 8'd0; r_a2[c] = 8'd0; m_busy[c] = 1'b0;
            end
        end else begin
            ok    = CFG_WR && CFG_SEL != 3'd7 && !m_busy[CFG_CH] && !(START && CH_MASK[CFG_CH]);
            e.err = CFG_WR && !ok;
            for (int c = 0; c < 4; c++) begin
                if (STOP) begin
                    m_busy[c] = 1'b0;
                end else if (!m_busy[c] && START && CH_MASK[c]) begin
                    start_ch(c);
                    if (m_fin[c] && m_len[c] == 0) begin
                        m_busy[c] = 1'b0; e.done[c] = 1'b1;
                    end
                end else if (m_busy[c] && TX_END) begin
                    m_k[c]++;
                    if (m_fin[c] && m_k[c] == m_len[c]) begin
                        m_busy[c] = 1'b0; e.done[c] = 1'b1;
                    end
                end
            end
            if (ok) begin
                case (CFG_SEL)
                    3'd0: r_pw1[CFG_CH] = 32'(CFG_DATA);
                    3'd1: r_ipg[CFG_CH] = 32'(CFG_DATA);
                    3'd2: r_pw2[CFG_CH] = 32'(CFG_DATA);
                    3'd3: r_per[CFG_CH] = 32'(CFG_DATA);
                    3'd4: r_np[CFG_CH]  = 32'(CFG_DATA);
                    3'd5: r_a1[CFG_CH]  = CFG_DATA[7:0];
                    default: r_a2[CFG_CH] = CFG_DATA[7:0];
                endcase
            end
        end
        e.a0 = m_busy[0] ? amp_at(0) : 8'd0;
        e.a1 = m_busy[1] ? amp_at(1) : 8'd0;
        e.a2 = m_busy[2] ? amp_at(2) : 8'd0;
        e.a3 = m_busy[3] ? amp_at(3) : 8'd0;
        for (int c = 0; c < 4; c++) e.busy[c] = m_busy[c];
        e.active = |e.busy;
        sb.push_back(e);
    endtask

    // Monitor: outputs are registered, so every cycle presents a fresh observation.
    initial begin
        obs_t exp_o, act_o;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                exp_o = sb.pop_front();
                act_o.a0 = AMP0; act_o.a1 = AMP1; act_o.a2 = AMP2; act_o.a3 = AMP3;
                act_o.busy = BUSY; act_o.done = DONE; act_o.active = ACTIVE; act_o.err = CFG_ERR;
                checks++;
                if (act_o !== exp_o) begin
                    errors++;
                    $display("FAIL cycle_obs t=%0t got amp=%h,%h,%h,%h busy=%b done=%b active=%b err=%b want amp=%h,%h,%h,%h busy=%b done=%b active=%b err=%b",
                             $time, act_o.a0, act_o.a1, act_o.a2, act_o.a3, act_o.busy, act_o.done,
                             act_o.active, act_o.err, exp_o.a0, exp_o.a1, exp_o.a2, exp_o.a3,
                             exp_o.busy, exp_o.done, exp_o.active, exp_o.err);
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        CFG_WR = 1'b0; START = 1'b0; STOP = 1'b0; TX_END = 1'b0; RST = 1'b0;
    endtask

    task automatic wr(int ch, int sel, int data);
        CFG_WR = 1'b1; CFG_CH = ch[1:0]; CFG_SEL = sel[2:0]; CFG_DATA = data[15:0];
        tick();
    endtask

    task automatic prog(int ch, int pw1, int ipg, int pw2, int per, int np, int a1, int a2);
        wr(ch, 0, pw1); wr(ch, 1, ipg); wr(ch, 2, pw2); wr(ch, 3, per);
        wr(ch, 4, np);  wr(ch, 5, a1);  wr(ch, 6, a2);
    endtask

    task automatic go(logic [3:0] mask);
        START = 1'b1; CH_MASK = mask;
        tick();
    endtask

    task automatic frames(int n, int gap);
        for (int i = 0; i < n; i++) begin
            TX_END = 1'b1;
            tick();
            repeat (gap - 1) tick();
        end
    endtask

    function automatic int rand_data(int sel);
        if (sel <= 2 || sel == 4) return int'($urandom_range(0, 3));
        if (sel == 3) return int'($urandom_range(0, 14));
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0] basic_tbl [13];
        int sel;
        basic_tbl = '{8'h40, 8'h40, 8'h00, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00,
                      8'h40, 8'h40, 8'h00, 8'h80, 8'h80};
        RST = 1'b1; CFG_WR = 1'b0; CFG_CH = '0; CFG_SEL = '0; CFG_DATA = '0;
        START = 1'b0; CH_MASK = '0; STOP = 1'b0; TX_END = 1'b0;
        tick();
        RST = 1'b1;
        tick();

        // Basic train on ch0 with directed per-frame amplitudes.
        prog(0, 2, 1, 2, 8, 2, 'h40, 'h80);
        go(4'b0001);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("basic_amp%0d", i), 32'(AMP0), 32'(basic_tbl[i]));
            TX_END = 1'b1;
            tick();
            repeat (3) tick();
        end
        chk("basic_amp12", 32'(AMP0), 32'(basic_tbl[12]));
        TX_END = 1'b1;
        tick();
        chk("basic_done", {22'd0, BUSY[0], DONE[0], AMP0}, {22'd0, 1'b0, 1'b1, 8'h00});
        repeat (3) tick();

        // Skipped IPG and REST, continuous.
        wr(0, 1, 0); wr(0, 3, 3); wr(0, 4, 0);
        go(4'b0001);
        frames(10, 4);

        // STOP and START together with two busy channels.
        prog(1, 3, 1, 3, 10, 0, 'h11, 'h22);
        go(4'b0010);
        frames(2, 3);
        STOP = 1'b1; START = 1'b1; CH_MASK = 4'hF;
        tick();
        chk("stopstart", {BUSY, DONE, AMP0, AMP1, AMP2, AMP3}, 32'd0);
        tick();

        // Rejected writes.
        go(4'b0010);
        wr(1, 0, 7);
        chk("rej_busy", 32'(CFG_ERR), 32'd1);
        STOP = 1'b1;
        tick();
        wr(0, 7, 5);
        chk("rej_sel7", 32'(CFG_ERR), 32'd1);
        CFG_WR = 1'b1; CFG_CH = 2'd2; CFG_SEL = 3'd0; CFG_DATA = 16'd9;
        START = 1'b1; CH_MASK = 4'b0100;
        tick();
        chk("rej_start", 32'(CFG_ERR), 32'd1);
        frames(3, 2);
        STOP = 1'b1;
        tick();
        go(4'b0010);
        frames(12, 2);
        STOP = 1'b1;
        tick();

        // All-zero durations, three pulses on ch3.
        wr(3, 4, 3);
        go(4'b1000);
        chk("zero_start_nodone", {28'd0, DONE}, 32'd0);
        frames(4, 3);

        // Reset while ch0 is in PH2.
        prog(0, 2, 1, 2, 8, 2, 'h40, 'h80);
        go(4'b0001);
        frames(3, 2);
        chk("pre_rst_ph2", 32'(AMP0), 32'h80);
        RST = 1'b1;
        tick();
        chk("post_rst", {BUSY, AMP0}, 32'd0);
        go(4'b0001);
        frames(4, 2);
        STOP = 1'b1;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 10) begin
                sel = int'($urandom_range(0, 7));
                CFG_WR = 1'b1; CFG_CH = 2'($urandom_range(0, 3));
                CFG_SEL = 3'(sel); CFG_DATA = 16'(rand_data(sel));
            end
            if ($urandom_range(0, 99) < 5) begin
                START = 1'b1; CH_MASK = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 59) == 0) STOP = 1'b1;
            if ($urandom_range(0, 999) == 0) RST = 1'b1;
            TX_END = ($urandom_range(0, 2) == 0);
            tick();
        end

        repeat (2) @(negedge CLK);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
